// File: rtl/formula_1_pipe_bp.sv
// rtl/formula_1_pipe_bp.sv - res = isqrt(a)+isqrt(b)+isqrt(c) pipeline with credit-guarded output FIFO
// Optional statistics counters are enabled by defining FORMULA_PIPE_STATS_EN.
module formula_1_pipe_bp #(
  parameter int ARG_WIDTH  = 32,
  parameter int FIFO_DEPTH = 20,
  parameter int CNT_WIDTH  = 32,
  localparam int RES_WIDTH = ARG_WIDTH / 2 + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arg_vld,
  output logic                 arg_rdy,
  input  logic [ARG_WIDTH-1:0] a,
  input  logic [ARG_WIDTH-1:0] b,
  input  logic [ARG_WIDTH-1:0] c,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [RES_WIDTH-1:0] res
`ifdef FORMULA_PIPE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] n_cycles,
  output logic [CNT_WIDTH-1:0] arg_cnt,
  output logic [CNT_WIDTH-1:0] res_cnt
`endif
);

  localparam int H  = ARG_WIDTH / 2;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  // Stage 0 is the argument register; stage s holds s root bits per lane.
  logic [ARG_WIDTH-1:0] x_q    [0:H-1][0:2];
  logic [H-1:0]         rem_q  [0:H-1][0:2];
  logic [H-1:0]         root_q [0:H][0:2];
  logic [H+1:0]         sh     [1:H][0:2];
  logic [H+1:0]         tr     [1:H][0:2];
  logic                 ge     [1:H][0:2];
  logic [H+1:0]         vld_q;
  logic [RES_WIDTH-1:0] sum_q;

  logic [RES_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]        wr_ptr, rd_ptr, rd_nxt;
  logic [OW-1:0]        outstanding, fifo_cnt, left;
  logic [RES_WIDTH-1:0] res_nxt;
  logic                 accept, pop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign arg_rdy = outstanding < OW'(FIFO_DEPTH);
  assign accept  = arg_vld & arg_rdy;
  assign res_vld = fifo_cnt != '0;
  assign pop     = res_vld & res_rdy;
  assign push    = vld_q[H+1];

  always_comb begin
    for (int s = 1; s <= H; s++) begin
      for (int l = 0; l < 3; l++) begin
        sh[s][l] = {rem_q[s-1][l], x_q[s-1][l][2*(H-s) +: 2]};
        tr[s][l] = {root_q[s-1][l], 2'b01};
        ge[s][l] = sh[s][l] >= tr[s][l];
      end
    end
  end

  // Remainder never exceeds 2*root, so H bits suffice for every stored stage.
  always_ff @(posedge clk) begin
    x_q[0][0] <= a;
    x_q[0][1] <= b;
    x_q[0][2] <= c;
    for (int l = 0; l < 3; l++) begin
      rem_q[0][l]  <= '0;
      root_q[0][l] <= '0;
      for (int s = 1; s <= H; s++)
        root_q[s][l] <= {root_q[s-1][l][H-2:0], ge[s][l]};
      for (int s = 1; s < H; s++) begin
        rem_q[s][l] <= H'(ge[s][l] ? sh[s][l] - tr[s][l] : sh[s][l]);
        x_q[s][l]   <= x_q[s-1][l];
      end
    end
    sum_q <= RES_WIDTH'(root_q[H][0]) + RES_WIDTH'(root_q[H][1]) + RES_WIDTH'(root_q[H][2]);
    if (push)
      mem[wr_ptr] <= sum_q;
  end

  // res is registered so it holds its last value while the FIFO is empty.
  always_comb begin
    res_nxt = res;
    rd_nxt  = pop ? ptr_inc(rd_ptr) : rd_ptr;
    left    = fifo_cnt - OW'(pop);
    if (left != '0)
      res_nxt = mem[rd_nxt];
    else if (push)
      res_nxt = sum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      outstanding <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      res         <= '0;
    end else begin
      vld_q       <= {vld_q[H:0], accept};
      outstanding <= outstanding + OW'(accept) - OW'(pop);
      fifo_cnt    <= fifo_cnt + OW'(push) - OW'(pop);
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr <= rd_nxt;
      res    <= res_nxt;
    end
  end

`ifdef FORMULA_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      n_cycles <= '0;
      arg_cnt  <= '0;
      res_cnt  <= '0;
    end else begin
      n_cycles <= n_cycles + 1'b1;
      arg_cnt  <= arg_cnt + CNT_WIDTH'(accept);
      res_cnt  <= res_cnt + CNT_WIDTH'(pop);
    end
  end
`endif

endmodule

// File: tb/tb_formula_1_pipe_bp.sv
// tb/tb_formula_1_pipe_bp.sv - randomized scoreboard bench for formula_1_pipe_bp
// A queue-based model tracks acceptance order, readiness time and expected sums.
module tb_formula_1_pipe_bp;

  localparam int LAT   = 18;
  localparam int DEPTH = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arg_vld = 1'b0;
  logic        arg_rdy;
  logic [31:0] a = '0, b = '0, c = '0;
  logic        res_vld;
  logic        res_rdy = 1'b0;
  logic [17:0] res;
`ifdef FORMULA_PIPE_STATS_EN
  logic [31:0] n_cycles, arg_cnt, res_cnt;
`endif

  formula_1_pipe_bp dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .a(a), .b(b), .c(c), .res_vld(res_vld), .res_rdy(res_rdy), .res(res)
`ifdef FORMULA_PIPE_STATS_EN
    , .n_cycles(n_cycles), .arg_cnt(arg_cnt), .res_cnt(res_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0, n_checks = 0;

  typedef struct {
    logic [17:0] val;
    int          rdy;
  } ent_t;
  ent_t q[$];

  function automatic int unsigned isqrt(input logic [31:0] x);
    longint unsigned lo = 0, hi = 65535, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else hi = mid - 1;
    end
    return int'(lo);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: checks every cycle, then advances the model for the coming edge.
  initial begin : compare
    int   ncyc;
    logic exp_vld, mrdy;
    ncyc = 0;
    forever begin
      @(negedge clk);
      exp_vld = q.size() > 0 && q[0].rdy <= ncyc;
      mrdy    = q.size() < DEPTH;
      check("arg_rdy", 64'(arg_rdy), 64'(mrdy));
      check("res_vld", 64'(res_vld), 64'(exp_vld));
      if (exp_vld) check("res", 64'(res), 64'(q[0].val));
      if (rst) q.delete();
      else begin
        if (exp_vld && res_rdy) void'(q.pop_front());
        if (arg_vld && mrdy) begin
          q.push_back('{18'(isqrt(a) + isqrt(b) + isqrt(c)), ncyc + LAT + 1});
          n_vec++;
        end
      end
      ncyc++;
    end
  end

  task automatic wait_vld(output int n);
    n = 0;
    while (res_vld !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    int g;
    res_rdy = 1'b1;
    arg_vld = 1'b0;
    g = 0;
    while (q.size() > 0 && g < 300) begin
      tick();
      g++;
    end
    check("drain_done", 64'(q.size()), 64'd0);
  endtask

  task automatic single_146(input string tag);
    int n;
    a = 1; b = 4; c = 9;
    arg_vld = 1'b1;
    res_rdy = 1'b1;
    tick();
    arg_vld = 1'b0;
    wait_vld(n);
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    check({tag, "_res"}, 64'(res), 64'd6);
  endtask

  initial begin : main
    int n, acc, g;
    logic [17:0] exp2 [5];
    logic [31:0] vals [5];
    exp2 = '{18'd0, 18'd3, 18'd6, 18'd9, 18'd18};
    vals = '{32'd0, 32'd1, 32'd4, 32'd13, 32'd40};

    check("model_isqrt_max", 64'(isqrt(32'hFFFF_FFFF)), 64'd65535);
    check("model_isqrt_40", 64'(isqrt(32'd40)), 64'd6);
    check("model_isqrt_15", 64'(isqrt(32'd15)), 64'd3);

    repeat (3) tick();
    rst = 1'b0;
    check("reset_arg_rdy", 64'(arg_rdy), 64'd1);
    check("reset_res_vld", 64'(res_vld), 64'd0);
    check("reset_res", 64'(res), 64'd0);

    // 1: single argument, fixed latency
    single_146("t1");
    drain();

    // 2: back-to-back arguments, consecutive results
    res_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = vals[i]; b = vals[i]; c = vals[i];
      arg_vld = 1'b1;
      tick();
    end
    arg_vld = 1'b0;
    wait_vld(n);
    for (int j = 0; j < 5; j++) begin
      check("t2_vld", 64'(res_vld), 64'd1);
      check("t2_res", 64'(res), 64'(exp2[j]));
      tick();
    end
    drain();

    // 3: maximum arguments
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c = 32'hFFFF_FFFF;
    arg_vld = 1'b1;
    tick();
    b = 0; c = 0;
    tick();
    arg_vld = 1'b0;
    wait_vld(n);
    check("t3_max3", 64'(res), 64'd196605);
    tick();
    check("t3_max1", 64'(res), 64'd65535);
    drain();

    // 4: backpressure fills exactly FIFO_DEPTH credits
    res_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      a = i; b = i + 1; c = 2 * i;
      arg_vld = 1'b1;
      if (arg_rdy) acc++;
      tick();
    end
    arg_vld = 1'b0;
    check("t4_accepts", 64'(acc), 64'(DEPTH));
    check("t4_rdy_full", 64'(arg_rdy), 64'd0);
    repeat (20) tick();
    check("t4_head", 64'(res), 64'd1);
    res_rdy = 1'b1;
    check("t4_rdy_before_pop", 64'(arg_rdy), 64'd0);
    tick();
    check("t4_rdy_after_pop", 64'(arg_rdy), 64'd1);
    drain();

    // 5: random traffic and random consumer stalls
    acc = 0;
    g = 0;
    while (acc < 200 && g < 5000) begin
      arg_vld = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      c = $urandom_range(0, 1000);
      res_rdy = $urandom_range(0, 1);
      if (arg_vld && arg_rdy) acc++;
      tick();
      g++;
    end
    arg_vld = 1'b0;
    check("t5_accepts", 64'(acc), 64'd200);
    drain();

    // 6: reset with work in flight
    res_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; c = $urandom;
      arg_vld = 1'b1;
      tick();
    end
    arg_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_res_vld", 64'(res_vld), 64'd0);
    check("t6_arg_rdy", 64'(arg_rdy), 64'd1);
`ifdef FORMULA_PIPE_STATS_EN
    check("t6_n_cycles", 64'(n_cycles), 64'd0);
    check("t6_arg_cnt", 64'(arg_cnt), 64'd0);
    check("t6_res_cnt", 64'(res_cnt), 64'd0);
`endif
    single_146("t6");
    drain();
    repeat (30) tick();
    check("final_res_vld", 64'(res_vld), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
